// File: rtl/flight_arm_sequencer.sv
// ---------------------------------------------------------------------------
// flight_arm_sequencer
//
// Arming / failsafe controller placed between motor_mixer and pwm_generator.
// It also schedules the attitude pipeline:
//   - An IMU sample starts angle_controller (ac_start).
//   - Completion is tracked through the body-frame controller strobe.
// Motor rates are passed through only while ARMED. In every other state
// they are forced to IDLE_RATE.
//
// Ports
//   sys_clk            system clock
//   reset              asynchronous, active-high reset
//   imu_good           IMU healthy flag
//   imu_valid_strobe   1-cycle pulse, new IMU sample available
//   bf_valid_strobe    1-cycle pulse, body-frame PID finished
//   throttle_val       receiver throttle channel
//   arm_sw_val         receiver arm-switch channel
//   motor_[1-4]_in     rates from motor_mixer
//   motor_[1-4]_out    gated rates to pwm_generator (1-cycle latency)
//   ac_start           1-cycle start pulse to angle_controller
//   armed              state == ARMED
//   fault              state == FAILSAFE
//   state              0 DISARMED, 1 ARM_WAIT, 2 ARMED, 3 FAILSAFE
//   overrun_cnt        saturating count of IMU samples dropped while busy
// ---------------------------------------------------------------------------
module flight_arm_sequencer #(
    parameter int REC_W       = 8,
    parameter int MOTOR_W     = 8,
    parameter int THR_ARM_MAX = 10,
    parameter int SW_ON_MIN   = 128,
    parameter int ARM_HOLD    = 38000000,
    parameter int WD_TIMEOUT  = 760000,
    parameter int IDLE_RATE   = 0
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               imu_good,
    input  logic               imu_valid_strobe,
    input  logic               bf_valid_strobe,
    input  logic [REC_W-1:0]   throttle_val,
    input  logic [REC_W-1:0]   arm_sw_val,
    input  logic [MOTOR_W-1:0] motor_1_in,
    input  logic [MOTOR_W-1:0] motor_2_in,
    input  logic [MOTOR_W-1:0] motor_3_in,
    input  logic [MOTOR_W-1:0] motor_4_in,
    output logic [MOTOR_W-1:0] motor_1_out,
    output logic [MOTOR_W-1:0] motor_2_out,
    output logic [MOTOR_W-1:0] motor_3_out,
    output logic [MOTOR_W-1:0] motor_4_out,
    output logic               ac_start,
    output logic               armed,
    output logic               fault,
    output logic [1:0]         state,
    output logic [7:0]         overrun_cnt
);

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_ARM_WAIT = 2'd1;
    localparam logic [1:0] ST_ARMED    = 2'd2;
    localparam logic [1:0] ST_FAILSAFE = 2'd3;

    localparam int HOLD_W = (ARM_HOLD   > 1) ? $clog2(ARM_HOLD)   : 1;
    localparam int WD_W   = (WD_TIMEOUT > 1) ? $clog2(WD_TIMEOUT) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(ARM_HOLD - 1);
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(WD_TIMEOUT - 1);
    localparam logic [MOTOR_W-1:0] IDLE_VAL  = MOTOR_W'(IDLE_RATE);
    localparam logic [REC_W-1:0]   SW_ON     = REC_W'(SW_ON_MIN);
    localparam logic [REC_W-1:0]   THR_MAX   = REC_W'(THR_ARM_MAX);

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              busy_q, busy_d;
    logic [WD_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic              ac_start_q, ac_start_d;
    logic [7:0]        overrun_q, overrun_d;

    logic cond_arm;
    logic sw_on;
    logic wd_expired;
    logic busy_eff;
    logic start_now;

    assign sw_on      = (arm_sw_val >= SW_ON);
    assign cond_arm   = imu_good && sw_on && (throttle_val <= THR_MAX);
    assign wd_expired = (wd_cnt_q == WD_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_DISARMED;
            hold_cnt_q <= '0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // hold_cnt counts the cond_arm cycles spent in ARM_WAIT. It starts at 0 on entry.
    // wd_cnt counts cycles since the last bf strobe while ARMED. It starts at 0 on entry.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        wd_cnt_d   = '0;
        unique case (state_q)
            ST_DISARMED: begin
                if (cond_arm) state_d = ST_ARM_WAIT;
            end
            ST_ARM_WAIT: begin
                if (!cond_arm) begin
                    state_d = ST_DISARMED;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_ARMED;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_ARMED: begin
                // A health fault outranks a switch-off request in the same cycle.
                if (!imu_good || wd_expired) begin
                    state_d = ST_FAILSAFE;
                end else if (!sw_on) begin
                    state_d = ST_DISARMED;
                end else if (!bf_valid_strobe) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            ST_FAILSAFE: begin
                // Only a switch-off leaves FAILSAFE, so re-arming needs an off/on cycle.
                if (!sw_on) state_d = ST_DISARMED;
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        armed = (state_q == ST_ARMED);
        fault = (state_q == ST_FAILSAFE);
        state = state_q;
    end

    // ---------------- Pipeline scheduling ----------------
    // busy_eff is the busy flag after any clear in this cycle.
    // A bf strobe that coincides with an IMU strobe therefore lets the new start through.
    assign busy_eff  = busy_q && !bf_valid_strobe && (busy_cnt_q != WD_LAST);
    assign start_now = imu_valid_strobe && imu_good && !busy_eff;

    always_comb begin
        ac_start_d = start_now;
        busy_d     = start_now || busy_eff;
        busy_cnt_d = '0;
        if (!start_now && busy_eff) busy_cnt_d = busy_cnt_q + 1'b1;
        overrun_d = overrun_q;
        if (imu_valid_strobe && imu_good && busy_eff && (overrun_q != 8'hFF))
            overrun_d = overrun_q + 8'd1;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            busy_q     <= 1'b0;
            busy_cnt_q <= '0;
            ac_start_q <= 1'b0;
            overrun_q  <= 8'd0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            ac_start_q <= ac_start_d;
            overrun_q  <= overrun_d;
        end
    end

    assign ac_start    = ac_start_q;
    assign overrun_cnt = overrun_q;

    // ---------------- Motor gate ----------------
    logic [MOTOR_W-1:0] motor_in  [4];
    logic [MOTOR_W-1:0] motor_out [4];

    assign motor_in[0] = motor_1_in;
    assign motor_in[1] = motor_2_in;
    assign motor_in[2] = motor_3_in;
    assign motor_in[3] = motor_4_in;

    // The gate decision uses the registered state, so out[n+1] follows state[n].
    for (genvar gi = 0; gi < 4; gi++) begin : g_motor
        logic [MOTOR_W-1:0] rate_q;
        always_ff @(posedge sys_clk or posedge reset) begin
            if (reset) rate_q <= IDLE_VAL;
            else       rate_q <= (state_q == ST_ARMED) ? motor_in[gi] : IDLE_VAL;
        end
        assign motor_out[gi] = rate_q;
    end

    assign motor_1_out = motor_out[0];
    assign motor_2_out = motor_out[1];
    assign motor_3_out = motor_out[2];
    assign motor_4_out = motor_out[3];

endmodule
